// File: rtl/alu_wb_stage.sv
// ---------------------------------------------------------------------------
// alu_wb_stage
// Execute-to-writeback pipeline stage that sits directly behind the
// combinational ALU. It registers the ALU result, destination register and
// write enable behind a valid/ready handshake. A 2-entry buffer (main + skid)
// lets in_ready be a plain register output. The stage also holds the
// architectural NZCV flag register and corrects the ALU flags for logic ops.
//
// The ALU's flag mux only decodes selector[1:0], so for logic ops
// (selector >= 4) its raw flags are recomputed here from the result.
//
// Parameters:
//   bus          - data width of ALU result / writeback data
//   bus_selector - width of ALU op selector
//   reg_addr     - width of destination register address
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - drop every buffered beat and the beat offered this cycle
//   in_valid/ready  - upstream handshake (in_ready is registered)
//   in_result       - ALU result
//   in_selector     - ALU op of this beat
//   in_overflow, in_zero, in_negative, in_carry_out - raw ALU flags
//   in_rd, in_we    - destination register and register-file write request
//   in_flags_we     - update the flag register with this beat
//   out_valid/ready - writeback handshake
//   out_result, out_rd, out_we - registered writeback payload
//   flags           - architectural flags {V,Z,N,C}
//
// Optional feature (macro ALU_WB_STATS_EN):
//   stat_ops    - saturating count of writeback transfers
//   stat_stalls - saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module alu_wb_stage #(
    parameter int unsigned bus          = 4,
    parameter int unsigned bus_selector = 4,
    parameter int unsigned reg_addr     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [bus-1:0]          in_result,
    input  logic [bus_selector-1:0] in_selector,
    input  logic                    in_overflow,
    input  logic                    in_zero,
    input  logic                    in_negative,
    input  logic                    in_carry_out,
    input  logic [reg_addr-1:0]     in_rd,
    input  logic                    in_we,
    input  logic                    in_flags_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [bus-1:0]          out_result,
    output logic [reg_addr-1:0]     out_rd,
    output logic                    out_we,
    output logic [3:0]              flags
`ifdef ALU_WB_STATS_EN
    ,
    output logic [15:0]             stat_ops,
    output logic [15:0]             stat_stalls
`endif
);

    localparam int unsigned STAT_W = 16;

    // Writeback payload carried through the buffer
    typedef struct packed {
        logic [bus-1:0]      result;
        logic [reg_addr-1:0] rd;
        logic                we;
    } wb_beat_t;

    // State registers
    logic     r_main_valid;
    logic     r_skid_valid;
    logic     r_in_ready;
    wb_beat_t r_main;
    wb_beat_t r_skid;
    logic [3:0] r_flags;

    // Combinational helpers and next-state values
    logic       w_accept;
    logic       w_drain;
    logic       w_main_free;
    logic       w_logic_op;
    wb_beat_t   w_beat;
    logic [3:0] w_flags_corr;
    logic       w_main_valid_nxt;
    logic       w_skid_valid_nxt;
    wb_beat_t   w_main_nxt;
    wb_beat_t   w_skid_nxt;
    logic [3:0] w_flags_nxt;

    // A beat offered during flush is dropped, so it never counts as accepted
    assign w_accept    = in_valid & r_in_ready & ~flush;
    assign w_drain     = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | w_drain;

    assign w_beat.result = in_result;
    assign w_beat.rd     = in_rd;
    assign w_beat.we     = in_we;

    // Flag correction: logic ops derive Z/N from the result, clear C/V
    assign w_logic_op = (in_selector > bus_selector'(3));

    always_comb begin
        w_flags_corr = {in_overflow, in_zero, in_negative, in_carry_out};
        if (w_logic_op) begin
            w_flags_corr = {1'b0, (in_result == '0), in_result[bus-1], 1'b0};
        end
    end

    // Next-state for main/skid entries and the flag register
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_flags_nxt      = r_flags;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else begin
            if (w_main_free) begin
                // Skid holds the older beat; in_ready is low whenever it is
                // valid, so no new beat can arrive in the same cycle
                if (r_skid_valid) begin
                    w_main_nxt       = r_skid;
                    w_main_valid_nxt = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                end else begin
                    w_main_valid_nxt = w_accept;
                    if (w_accept) begin
                        w_main_nxt = w_beat;
                    end
                end
            end else if (w_accept) begin
                w_skid_nxt       = w_beat;
                w_skid_valid_nxt = 1'b1;
            end

            // Flags follow upstream order, independent of downstream stall
            if (w_accept && in_flags_we) begin
                w_flags_nxt = w_flags_corr;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
            r_flags      <= 4'b0000;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_flags      <= w_flags_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_main_valid;
    assign out_result = r_main.result;
    assign out_rd     = r_main.rd;
    assign out_we     = r_main.we;
    assign flags      = r_flags;

`ifdef ALU_WB_STATS_EN
    logic [STAT_W-1:0] r_stat_ops;
    logic [STAT_W-1:0] r_stat_stalls;

    // Saturating activity counters; flush leaves them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ops    <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_drain && (r_stat_ops != {STAT_W{1'b1}})) begin
                r_stat_ops <= r_stat_ops + STAT_W'(1);
            end
            if (r_main_valid && !out_ready && (r_stat_stalls != {STAT_W{1'b1}})) begin
                r_stat_stalls <= r_stat_stalls + STAT_W'(1);
            end
        end
    end

    assign stat_ops    = r_stat_ops;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the combinational ALU.
- Registers the ALU result, destination register address and write-enable behind a valid/ready handshake, with a 2-entry skid buffer so `in_ready` is a pure register output.
- Holds the architectural NZCV flag register.
- Corrects flags for logic ops: the ALU's flag mux only decodes `selector[1:0]`, so its flags are meaningless for selector 4..15.

Parameters:
- bus, 4, data width of ALU result and writeback data.
- bus_selector, 4, width of ALU op selector.
- reg_addr, 4, width of destination register address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all buffered entries.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat; registered.
- in_result  input  bus  ALU result.
- in_selector  input  bus_selector  ALU op of this beat.
- in_overflow, in_zero, in_negative, in_carry_out  input  1 each  raw ALU flags.
- in_rd  input  reg_addr  destination register.
- in_we  input  1  register-file write request.
- in_flags_we  input  1  update flag register with this beat.
- out_valid  output  1  writeback beat present.
- out_ready  input  1  writeback consumer accepts.
- out_result  output  bus  registered result.
- out_rd  output  reg_addr  registered destination.
- out_we  output  1  registered write request.
- flags  output  4  architectural flags {V,Z,N,C}.

Behaviour:
- Reset (rst=1 at edge): main and skid entries invalid; out_valid=0, in_ready=1, out_result=0, out_rd=0, out_we=0, flags=4'b0000. Reset overrides flush and handshakes.
- Accept: accept = in_valid & in_ready. Transfer out: out_valid & out_ready.
- Main entry drives outputs. Latency is one cycle from accept to out_valid when main is empty or draining. Throughput is one beat per cycle.
- Edge update, in order:
  - If main is empty or drains this cycle, main loads the skid entry if valid (skid then empties); otherwise it loads the accepted beat.
  - If main is valid and not draining, an accepted beat goes to skid.
- in_ready = ~skid_valid, registered; deasserts the cycle after skid fills.
- A beat is never duplicated or dropped except by flush. Order is strictly FIFO.
- Payload is stable while out_valid=1 and out_ready=0.
- Flag correction, applied on accept:
  - selector 0..3 (add/sub/mul/div): flags come from the ALU as given.
  - selector ≥ 4 (logic ops): Z = (in_result==0), N = in_result[bus-1], C = 0, V = 0.
- Flag update:
  - On accept with in_flags_we=1, flags <= corrected flags in that same edge, in upstream order, independent of downstream stall.
  - in_flags_we=0 leaves flags unchanged.
- Flush:
  - main and skid go invalid next edge; out_valid=0, in_ready=1.
  - A beat presented in the flush cycle is dropped and does not update flags.
  - flags register is not cleared.
- out_we is meaningful only when out_valid=1.

Optional Feature:
- Macro: ALU_WB_STATS_EN
- Enabled: adds outputs stat_ops and stat_stalls, 16 bits each.
  - stat_ops increments on each out transfer.
  - stat_stalls increments each cycle with out_valid=1 & out_ready=0.
  - Both saturate at 16'hFFFF and reset to 0 on rst. Flush does not clear them.
- Disabled: ports and counters absent; no other behaviour changes.

Test Plan:
- Reset, then add beat (in_result=4'h5, selector=0, rd=3, we=1, flags_we=1, V/Z/N/C=0/0/0/1) with out_ready=1 → next cycle out_valid=1, out_result=5, out_rd=3, flags=4'b0001.
- Logic op (selector=4, in_result=4'h0, ALU flags V=1,C=1, flags_we=1) → flags=4'b0100. Then selector=10, in_result=4'h8 → flags=4'b0010.
- out_ready=0, three back-to-back beats 1,2,3 → in_ready drops after beat 2 and beat 3 is held upstream. Release out_ready → outputs 1,2,3 in order, no loss.
- Stalled beat A with flags_we=1 followed by beat B with flags_we=0 → flags reflect A at A's accept edge and are unchanged by B.
- Two entries buffered, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, flags unchanged, flushed beat never appears.
- rst asserted while a beat is stalled → all outputs return to reset values next edge. With ALU_WB_STATS_EN, counters also read 0.
